// File: rtl/hazard_stall_unit_if.sv
// Pipeline-side bundle for the hazard/stall controller.
// The slave modport is the controller; master is the pipeline.
interface hazard_stall_unit_if #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
);
    logic [REG_W-1:0] d_rs;
    logic [REG_W-1:0] d_rt;
    logic             d_use_rs;
    logic             d_use_rt;
    logic             d_is_branch;
    logic             d_is_md;
    logic [REG_W-1:0] e_wa;
    logic             e_wen;
    logic             e_is_load;
    logic             e_md_start;
    logic             e_md_div;
    logic [REG_W-1:0] m_wa;
    logic             m_wen;
    logic             m_is_load;
    logic             pc_en;
    logic             d_en;
    logic             e_clr;
    logic             stall;
    logic [1:0]       stall_cause;
    logic             md_busy;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output d_rs, d_rt, d_use_rs, d_use_rt, d_is_branch, d_is_md,
        output e_wa, e_wen, e_is_load, e_md_start, e_md_div,
        output m_wa, m_wen, m_is_load,
        input  pc_en, d_en, e_clr, stall, stall_cause, md_busy, stall_cnt
    );

    modport slave (
        input  d_rs, d_rt, d_use_rs, d_use_rt, d_is_branch, d_is_md,
        input  e_wa, e_wen, e_is_load, e_md_start, e_md_div,
        input  m_wa, m_wen, m_is_load,
        output pc_en, d_en, e_clr, stall, stall_cause, md_busy, stall_cnt
    );
endinterface

// File: rtl/hazard_stall_unit.sv
// Load-use / branch-in-D / mult-div stall controller with HI/LO
// occupancy counter and saturating stall performance counter.
module hazard_stall_unit #(
    parameter int REG_W       = 5,
    parameter int MULT_LAT    = 5,
    parameter int DIV_LAT     = 10,
    parameter int LAT_W       = 4,
    parameter int CNT_W       = 16,
    parameter int BRANCH_IN_D = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    hazard_stall_unit_if.slave hz
);
    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state, state_n;
    logic [LAT_W-1:0] cnt, cnt_n;
    logic [CNT_W-1:0] scnt;
    logic             e_hit, m_hit;
    logic             load_haz, br_haz, md_haz;
    logic             stall, md_busy;
    logic [1:0]       cause;

    always_comb begin
        e_hit = (hz.d_use_rs && (hz.d_rs == hz.e_wa)) ||
                (hz.d_use_rt && (hz.d_rt == hz.e_wa));
        m_hit = (hz.d_use_rs && (hz.d_rs == hz.m_wa)) ||
                (hz.d_use_rt && (hz.d_rt == hz.m_wa));
    end

    assign load_haz = hz.e_is_load && hz.e_wen &&
                      (hz.e_wa != '0) && e_hit;

    generate
        if (BRANCH_IN_D != 0) begin : g_br
            assign br_haz = hz.d_is_branch && (
                (hz.e_wen && !hz.e_is_load && (hz.e_wa != '0) && e_hit) ||
                (hz.m_wen && hz.m_is_load && (hz.m_wa != '0) && m_hit));
        end else begin : g_no_br
            assign br_haz = 1'b0;
        end
    endgenerate

    assign md_busy = (cnt != '0);
    assign md_haz  = hz.d_is_md && (md_busy || hz.e_md_start);
    assign stall   = load_haz || br_haz || md_haz;

    // Load-use wins over branch, branch over mult/div.
    always_comb begin
        cause = 2'b00;
        if (load_haz)    cause = 2'b01;
        else if (br_haz) cause = 2'b10;
        else if (md_haz) cause = 2'b11;
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        unique case (state)
            IDLE: begin
                if (hz.e_md_start) begin
                    cnt_n   = hz.e_md_div ? LAT_W'(DIV_LAT) : LAT_W'(MULT_LAT);
                    state_n = BUSY;
                end
            end
            BUSY: begin
                cnt_n = cnt - 1'b1;
                if (cnt == LAT_W'(1)) state_n = IDLE;
            end
            default: begin
                cnt_n   = '0;
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) scnt <= '0;
        else if (stall && (scnt != {CNT_W{1'b1}})) scnt <= scnt + 1'b1;
    end

    assign hz.stall       = stall;
    assign hz.pc_en       = !stall;
    assign hz.d_en        = !stall;
    assign hz.e_clr       = stall;
    assign hz.stall_cause = cause;
    assign hz.md_busy     = md_busy;
    assign hz.stall_cnt   = scnt;
endmodule
